accelerator_read_content_scheduler: RTL and testbench
=====================================================

# accelerator_read_content_scheduler

Sequencer that time-shares one read content-weighting engine among R read heads of the DNC memory. For each head i it starts the engine, streams the key k(t;i;k) and then the memory M(t-1;j;k) row by row through the engine's input enables, and collects the N content weights c(t;i;j). It sits between the read-head parameter/memory buffers and the content-weighting engine. It drives buffer addresses and engine enables only; data words flow directly from the buffers to the engine.

## Interface
Parameters:
- DATA_SIZE, 64, width of sizes, indices and data
- CONTROL_SIZE, 64, control width (passed through; not used internally)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- START  in  1  run request, honoured only while READY=1
- READY  out  1  high when idle
- ERROR  out  1  sticky fault flag, cleared by an accepted START
- SIZE_R_IN  in  DATA_SIZE  number of read heads R, sampled at START
- SIZE_N_IN  in  DATA_SIZE  memory rows N, sampled at START
- SIZE_W_IN  in  DATA_SIZE  word width W, sampled at START
- DATA_VALID_IN  in  1  buffers present valid K/M data this cycle
- HEAD_OUT  out  DATA_SIZE  current head index i
- ROW_OUT  out  DATA_SIZE  current row index j
- WORD_OUT  out  DATA_SIZE  current word index k
- CWE_START  out  1  engine start pulse
- CWE_READY  in  1  engine finished current head
- CWE_K_IN_ENABLE  out  1  key element k presented
- CWE_M_IN_J_ENABLE  out  1  first element of memory row j presented
- CWE_M_IN_K_ENABLE  out  1  memory element (j,k) presented
- CWE_C_OUT_ENABLE  in  1  engine emits weight c(i;j)
- C_OUT_ENABLE  out  1  forwarded weight strobe
- C_I_OUT  out  DATA_SIZE  head index of forwarded weight
- C_J_OUT  out  DATA_SIZE  row index of forwarded weight

## Operation
- States: IDLE, ENGINE_START, LOAD_K, LOAD_M, WAIT_C, NEXT_HEAD.
- IDLE: READY=1. START=1 with R, N, W all nonzero → latch sizes, clear ERROR, zero i/j/k and the weight counter c, go to ENGINE_START. START with any size zero → ERROR=1, stay in IDLE.
- ENGINE_START: CWE_START=1 for exactly one cycle → LOAD_K.
- LOAD_K: in each cycle with DATA_VALID_IN=1, assert CWE_K_IN_ENABLE and increment k. A valid cycle at k=W-1 sets k=0 → LOAD_M.
- LOAD_M: in each valid cycle, assert CWE_M_IN_K_ENABLE. Also assert CWE_M_IN_J_ENABLE when k=0. k wraps at W-1 and then increments j. A valid cycle at (j=N-1, k=W-1) sets j=0 → WAIT_C.
- Stall: DATA_VALID_IN=0 in LOAD_K/LOAD_M → all CWE_*_IN_ENABLE=0 and indices hold.
- CWE_C_OUT_ENABLE is accepted in any non-IDLE state. It produces C_OUT_ENABLE=1, C_I_OUT=i, C_J_OUT=c, and increments c. A pulse while c=N is dropped and sets ERROR.
- WAIT_C: wait for CWE_READY=1. If c≠N at that point → ERROR=1, advance anyway → NEXT_HEAD.
- NEXT_HEAD: c=0. If i=R-1 → IDLE, else increment i → ENGINE_START.
- START while READY=0 is ignored.
- Index and size arithmetic is unsigned DATA_SIZE. Compares use size-1 on the latched sizes.

## Timing
- Reset values: READY=1, ERROR=0, all enables/strobes 0, HEAD_OUT=ROW_OUT=WORD_OUT=C_I_OUT=C_J_OUT=0, state IDLE.
- RST mid-run returns to the reset values at the next edge. No partial results are flushed.
- START accepted at edge e: READY=0 and CWE_START=1 in cycle e+1.
- Indices are registered. CWE_*_IN_ENABLE are combinational from state and DATA_VALID_IN, aligned with the index outputs in the same cycle.
- C_OUT_ENABLE, C_I_OUT and C_J_OUT are registered, one cycle after CWE_C_OUT_ENABLE.
- With no stalls, ENGINE_START→WAIT_C takes 1+W+N·W cycles. CWE_READY is seen the first cycle it is high in WAIT_C; NEXT_HEAD lasts one cycle.
- A CWE_C_OUT_ENABLE coinciding with CWE_READY is counted before the c=N check.

## Test plan
- R=2, N=3, W=4, valid always, engine returns 3 C pulses then READY. Required: 2 CWE_START pulses, 4 K enables and 12 M_K/3 M_J enables per head, C_OUT pairs (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), READY=1 afterwards, ERROR=0.
- Same configuration with DATA_VALID_IN toggling 1,0,1,0. Required: enable counts unchanged, indices hold during 0 cycles, enable/index sequence identical with gaps inserted.
- START with SIZE_W_IN=0. Required: ERROR=1, READY stays 1, no CWE_START. A following valid START clears ERROR.
- Engine raises READY after only 2 C pulses for head 0. Required: ERROR=1, head 1 still runs to completion.
- RST asserted in LOAD_M at j=1, k=2. Required: all outputs at reset values next cycle. A new START runs cleanly from i=j=k=0.
- START pulsed during WAIT_C. Required: ignored; the run completes exactly as in the first scenario.

Source files
------------

// File: rtl/accelerator_read_content_scheduler.sv
// Sequencer sharing one content-weighting engine across R read heads: starts the
// engine per head, streams key then memory indices, and forwards the weight strobes.
module accelerator_read_content_scheduler #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 DATA_VALID_IN,
  output logic [DATA_SIZE-1:0] HEAD_OUT,
  output logic [DATA_SIZE-1:0] ROW_OUT,
  output logic [DATA_SIZE-1:0] WORD_OUT,
  output logic                 CWE_START,
  input  logic                 CWE_READY,
  output logic                 CWE_K_IN_ENABLE,
  output logic                 CWE_M_IN_J_ENABLE,
  output logic                 CWE_M_IN_K_ENABLE,
  input  logic                 CWE_C_OUT_ENABLE,
  output logic                 C_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] C_I_OUT,
  output logic [DATA_SIZE-1:0] C_J_OUT
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_ENGINE_START = 3'd1;
  localparam logic [2:0] S_LOAD_K       = 3'd2;
  localparam logic [2:0] S_LOAD_M       = 3'd3;
  localparam logic [2:0] S_WAIT_C       = 3'd4;
  localparam logic [2:0] S_NEXT_HEAD    = 3'd5;

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  if (CONTROL_SIZE < 1) begin : g_control_size_check
    $error("CONTROL_SIZE must be positive");
  end

  logic [2:0]           state;
  logic [DATA_SIZE-1:0] size_r, size_n, size_w;
  logic [DATA_SIZE-1:0] head, row, word, c_cnt;
  logic [DATA_SIZE-1:0] c_next;
  logic                 c_accept, c_drop;
  logic                 last_word, last_row, last_head;

  assign READY             = (state == S_IDLE);
  assign CWE_START         = (state == S_ENGINE_START);
  assign CWE_K_IN_ENABLE   = (state == S_LOAD_K) && DATA_VALID_IN;
  assign CWE_M_IN_K_ENABLE = (state == S_LOAD_M) && DATA_VALID_IN;
  assign CWE_M_IN_J_ENABLE = CWE_M_IN_K_ENABLE && (word == '0);
  assign HEAD_OUT          = head;
  assign ROW_OUT           = row;
  assign WORD_OUT          = word;

  assign last_word = (word == size_w - ONE);
  assign last_row  = (row  == size_n - ONE);
  assign last_head = (head == size_r - ONE);

  // A weight pulse arriving with CWE_READY is counted before the completeness check.
  always_comb begin
    c_accept = 1'b0;
    c_drop   = 1'b0;
    c_next   = c_cnt;
    if (CWE_C_OUT_ENABLE && (state != S_IDLE)) begin
      if (c_cnt != size_n) begin
        c_accept = 1'b1;
        c_next   = c_cnt + ONE;
      end else begin
        c_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      size_r       <= '0;
      size_n       <= '0;
      size_w       <= '0;
      head         <= '0;
      row          <= '0;
      word         <= '0;
      c_cnt        <= '0;
      ERROR        <= 1'b0;
      C_OUT_ENABLE <= 1'b0;
      C_I_OUT      <= '0;
      C_J_OUT      <= '0;
    end else begin
      C_OUT_ENABLE <= c_accept;
      if (c_accept) begin
        C_I_OUT <= head;
        C_J_OUT <= c_cnt;
      end
      c_cnt <= c_next;
      if (c_drop) ERROR <= 1'b1;

      case (state)
        S_IDLE: begin
          if (START) begin
            if ((SIZE_R_IN != '0) && (SIZE_N_IN != '0) && (SIZE_W_IN != '0)) begin
              size_r <= SIZE_R_IN;
              size_n <= SIZE_N_IN;
              size_w <= SIZE_W_IN;
              ERROR  <= 1'b0;
              head   <= '0;
              row    <= '0;
              word   <= '0;
              c_cnt  <= '0;
              state  <= S_ENGINE_START;
            end else begin
              ERROR <= 1'b1;
            end
          end
        end
        S_ENGINE_START: state <= S_LOAD_K;
        S_LOAD_K: begin
          if (DATA_VALID_IN) begin
            if (last_word) begin
              word  <= '0;
              state <= S_LOAD_M;
            end else begin
              word <= word + ONE;
            end
          end
        end
        S_LOAD_M: begin
          if (DATA_VALID_IN) begin
            if (last_word) begin
              word <= '0;
              if (last_row) begin
                row   <= '0;
                state <= S_WAIT_C;
              end else begin
                row <= row + ONE;
              end
            end else begin
              word <= word + ONE;
            end
          end
        end
        S_WAIT_C: begin
          if (CWE_READY) begin
            if (c_next != size_n) ERROR <= 1'b1;
            state <= S_NEXT_HEAD;
          end
        end
        S_NEXT_HEAD: begin
          c_cnt <= '0;
          if (last_head) begin
            state <= S_IDLE;
          end else begin
            head  <= head + ONE;
            state <= S_ENGINE_START;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_read_content_scheduler.sv
// Scoreboard bench: the driver plays the buffers and the engine and queues expected
// weight pairs; a negedge monitor tracks index sequences and checks forwarded weights.
module tb_accelerator_read_content_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic        error;
  logic [63:0] size_r, size_n, size_w;
  logic        data_valid;
  logic [63:0] head_out, row_out, word_out;
  logic        cwe_start;
  logic        cwe_ready;
  logic        cwe_k_en, cwe_mj_en, cwe_mk_en;
  logic        cwe_c_en;
  logic        c_out_en;
  logic [63:0] c_i_out, c_j_out;

  always #5 clk = ~clk;

  accelerator_read_content_scheduler #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK(clk), .RST(rst), .START(start), .READY(ready), .ERROR(error),
    .SIZE_R_IN(size_r), .SIZE_N_IN(size_n), .SIZE_W_IN(size_w),
    .DATA_VALID_IN(data_valid),
    .HEAD_OUT(head_out), .ROW_OUT(row_out), .WORD_OUT(word_out),
    .CWE_START(cwe_start), .CWE_READY(cwe_ready),
    .CWE_K_IN_ENABLE(cwe_k_en), .CWE_M_IN_J_ENABLE(cwe_mj_en), .CWE_M_IN_K_ENABLE(cwe_mk_en),
    .CWE_C_OUT_ENABLE(cwe_c_en),
    .C_OUT_ENABLE(c_out_en), .C_I_OUT(c_i_out), .C_J_OUT(c_j_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  // configuration seen by the monitor
  int cfg_n = 1;
  int cfg_w = 1;

  // monitor state
  int exp_head = 0, cur_head = 0, exp_k = 0, exp_j = 0;
  int k_cnt = 0, mk_cnt = 0, mj_cnt = 0, total_starts = 0;
  bit loading = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ready) begin
      exp_head = 0; exp_k = 0; exp_j = 0; loading = 0;
    end
    if (cwe_start) begin
      chk("start_head", head_out, 128'(exp_head));
      chk("start_row", row_out, 0);
      chk("start_word", word_out, 0);
      cur_head = exp_head;
      exp_head++;
      k_cnt = 0; mk_cnt = 0; mj_cnt = 0;
      exp_k = 0; exp_j = 0;
      loading = 1;
      total_starts++;
    end
    if (cwe_k_en) begin
      chk("k_word", word_out, 128'(exp_k));
      chk("k_head", head_out, 128'(cur_head));
      k_cnt++;
      exp_k = (exp_k == cfg_w - 1) ? 0 : exp_k + 1;
    end
    if (cwe_mk_en) begin
      chk("m_row", row_out, 128'(exp_j));
      chk("m_word", word_out, 128'(exp_k));
      chk("m_j_enable", 128'(cwe_mj_en), 128'(exp_k == 0));
      mk_cnt++;
      if (cwe_mj_en) mj_cnt++;
      if (exp_k == cfg_w - 1) begin
        exp_k = 0;
        if (exp_j == cfg_n - 1) begin
          exp_j = 0;
          loading = 0;
        end else exp_j++;
      end else exp_k++;
    end
    if (loading && !data_valid) begin
      chk("stall_enables", {cwe_k_en, cwe_mk_en, cwe_mj_en}, 0);
      chk("stall_word_hold", word_out, 128'(exp_k));
      chk("stall_row_hold", row_out, 128'(exp_j));
    end
    if (c_out_en) begin
      if (exp_q.size() == 0) chk("c_out_expected", 0, 1);
      else chk("c_out_pair", {c_i_out, c_j_out}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_start(input int r, input int n, input int w);
    size_r = 64'(r); size_n = 64'(n); size_w = 64'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int r, input int n, input int w, input bit stall,
                     input int h0_pulses, input bit start_in_wait, input bit exp_err);
    int starts0;
    bit got;
    int cyc, vcnt, pulses;
    cfg_n = n; cfg_w = w;
    starts0 = total_starts;
    issue_start(r, n, w);
    chk("ready_low_after_start", 128'(ready), 0);
    chk("error_cleared_by_start", 128'(error), 0);
    for (int h = 0; h < r; h++) begin
      got = 0;
      for (int t = 0; t < 20; t++) begin
        if (cwe_start) begin got = 1; break; end
        tick();
      end
      if (!got) begin
        chk("cwe_start_timeout", 0, 1);
        return;
      end
      tick();
      cyc = 0; vcnt = 0;
      while (vcnt < w + n * w && cyc < 1000) begin
        data_valid = stall ? (cyc % 2 == 0) : 1'b1;
        tick();
        if (data_valid) vcnt++;
        cyc++;
      end
      data_valid = 1'b0;
      chk("k_enable_count", 128'(k_cnt), 128'(w));
      chk("mk_enable_count", 128'(mk_cnt), 128'(n * w));
      chk("mj_enable_count", 128'(mj_cnt), 128'(n));
      if (start_in_wait) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      pulses = (h == 0) ? h0_pulses : n;
      for (int p = 0; p < pulses; p++) begin
        cwe_c_en = 1'b1;
        if (p < n) exp_q.push_back({64'(h), 64'(p)});
        tick();
      end
      cwe_c_en  = 1'b0;
      cwe_ready = 1'b1;
      tick();
      cwe_ready = 1'b0;
    end
    for (int t = 0; t < 10; t++) begin
      if (ready) break;
      tick();
    end
    chk("ready_after_run", 128'(ready), 1);
    tick();
    chk("error_after_run", 128'(error), 128'(exp_err));
    chk("queue_drained", 128'(exp_q.size()), 0);
    chk("engine_start_count", 128'(total_starts - starts0), 128'(r));
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 128'(ready), 1);
    chk({tag, "_error"}, 128'(error), 0);
    chk({tag, "_enables"}, {cwe_start, cwe_k_en, cwe_mk_en, cwe_mj_en, c_out_en}, 0);
    chk({tag, "_indices"}, {head_out, row_out}, 0);
    chk({tag, "_word"}, word_out, 0);
    chk({tag, "_c_out"}, {c_i_out, c_j_out}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts0;
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; cwe_ready = 1'b0; cwe_c_en = 1'b0;
    size_r = '0; size_n = '0; size_w = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_values("reset");

    // nominal run
    run(2, 3, 4, 1'b0, 3, 1'b0, 1'b0);

    // alternating valid
    run(2, 3, 4, 1'b1, 3, 1'b0, 1'b0);

    // zero word width is refused
    starts0 = total_starts;
    issue_start(2, 3, 0);
    chk("zero_size_error", 128'(error), 1);
    chk("zero_size_ready", 128'(ready), 1);
    repeat (3) tick();
    chk("zero_size_no_start", 128'(total_starts - starts0), 0);
    chk("zero_size_error_sticky", 128'(error), 1);
    run(2, 3, 4, 1'b0, 3, 1'b0, 1'b0);

    // engine under-delivers for head 0
    run(2, 3, 4, 1'b0, 2, 1'b0, 1'b1);

    // reset during LOAD_M at j=1, k=2
    cfg_n = 3; cfg_w = 4;
    issue_start(2, 3, 4);
    chk("rst_scn_cwe_start", 128'(cwe_start), 1);
    tick();
    data_valid = 1'b1;
    repeat (10) tick();
    chk("rst_scn_row", row_out, 1);
    chk("rst_scn_word", word_out, 2);
    chk("rst_scn_in_load_m", 128'(cwe_mk_en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("mid_rst");
    data_valid = 1'b0;
    tick();
    run(2, 3, 4, 1'b0, 3, 1'b0, 1'b0);

    // START during WAIT_C is ignored
    run(2, 3, 4, 1'b0, 3, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
